ddr3_frame_packer: RTL and testbench
====================================

DDR3_FRAME_PACKER -- requirements
Module: ddr3_frame_packer

Interface
REQ-001 Parameter BITS_PER_SYMBOL, default 8, bits per colour symbol.
REQ-002 Parameter SYMBOLS_PER_BEAT, default 3, symbols per pixel; PW = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT (1..128).
REQ-003 Parameter WIDTH, default 1280, pixels per line.
REQ-004 Parameter HEIGHT, default 720, lines per frame.
REQ-005 Parameter BASE_ADDR, default 32'h0, byte address of word 0; derived PPW = floor(128/PW), NWORDS = ceil(WIDTH*HEIGHT/PPW).
REQ-006 One clock; reset is synchronous and active-high: clk, in, 1, clock; rst, in, 1, sync active-high reset.
REQ-007 start  in  1  frame-start pulse; mode  in  1  0=store, 1=fetch.
REQ-008 busy  out  1  frame operation in progress; done  out  1  one-cycle frame-complete pulse.
REQ-009 din_valid  in  1; din_ready  out  1; din_data  in  PW  store-mode pixel input.
REQ-010 dout_valid  out  1; dout_ready  in  1; dout_data  out  PW  fetch-mode pixel output.
REQ-011 sdram_address  out  32; rd_en  out  1; wr_en  out  1; write_data_input  out  128.
REQ-012 read_data  in  128; write_complete  in  1; read_complete  in  1.

Function
REQ-013 FSM states IDLE, FILL, WRITE, READ, DRAIN; busy=1 in every state except IDLE.
REQ-014 IDLE: start=1 latches mode, clears word_idx and slot counter; mode 0 -> FILL, mode 1 -> READ; start outside IDLE is ignored.
REQ-015 FILL: din_ready=1; each din_valid&din_ready beat places the pixel at bits [slot*PW +: PW], slot 0 at LSB.
REQ-016 FILL -> WRITE on the cycle accepting pixel PPW-1 or the frame's last pixel; unfilled slots and bits above PPW*PW are zero.
REQ-017 WRITE: wr_en=1 from the cycle after the final pixel is accepted; sdram_address = BASE_ADDR + 16*word_idx (mod 2^32); address and write_data_input are held stable until write_complete is sampled high.
REQ-018 On write_complete in WRITE: wr_en=0 next cycle and word_idx increments; if word_idx was NWORDS-1 -> done pulse, IDLE, else -> FILL.
REQ-019 READ: rd_en=1 starting the cycle after start (or after DRAIN), same address rule, held until read_complete; read_data captured in the read_complete cycle; -> DRAIN.
REQ-020 DRAIN: dout_valid=1; dout_data = slot field of the captured word, LSB slot first; slot advances only on dout_valid&dout_ready; dout_data held while not ready.
REQ-021 Last word emits only WIDTH*HEIGHT - (NWORDS-1)*PPW pixels; after the last pixel -> done pulse, IDLE; otherwise after PPW pixels -> READ with word_idx+1.
REQ-022 write_complete outside WRITE and read_complete outside READ are ignored.
REQ-023 din_ready=0 outside FILL; dout_valid=0 outside DRAIN; rd_en and wr_en never both 1.
REQ-024 Counters sized from parameters; no overflow for WIDTH*HEIGHT up to 2^24.

Reset
REQ-025 rst=1 at an edge forces IDLE next cycle; busy, done, din_ready, dout_valid, rd_en, wr_en = 0; sdram_address, write_data_input, dout_data = 0; counters = 0.
REQ-026 Reset mid WRITE/READ abandons the transaction; next start begins at BASE_ADDR word 0.

Verification (WIDTH=4, HEIGHT=2, PW=24, PPW=5, NWORDS=2 unless noted)
REQ-027 Store: start mode=0, pixels 1..8 streamed -> writes at BASE, BASE+16; word0 = pixels 1..5 LSB-first, bits 127:120 zero; word1 = 6,7,8, bits 127:72 zero; one done pulse.
REQ-028 write_complete delayed 10 cycles -> wr_en, address, data stable all 10 cycles, din_ready=0 throughout.
REQ-029 Fetch with dout_ready toggling randomly -> exactly 8 pixels in stored order, no drop or duplicate, rd_en at BASE then BASE+16.
REQ-030 rst pulsed during WRITE -> wr_en=0 and busy=0 next cycle; subsequent store writes first word to BASE.
REQ-031 start while busy and read_complete/write_complete in IDLE -> no state, address or output change.
REQ-032 SYMBOLS_PER_BEAT=4 (PW=32, PPW=4) -> 2 full words, no zero padding, done after 8 pixels.

Source files
------------

// File: rtl/ddr3_frame_packer_if.sv
// Bundle of the packer's control, pixel-stream and SDRAM-side signals.
// The master modport is the packer's own view; slave is the environment's view.
interface ddr3_frame_packer_if #(
    parameter int PW = 24
) ();
    logic          start;
    logic          mode;
    logic          busy;
    logic          done;
    logic          din_valid;
    logic          din_ready;
    logic [PW-1:0] din_data;
    logic          dout_valid;
    logic          dout_ready;
    logic [PW-1:0] dout_data;
    logic [31:0]   sdram_address;
    logic          rd_en;
    logic          wr_en;
    logic [127:0]  write_data_input;
    logic [127:0]  read_data;
    logic          write_complete;
    logic          read_complete;

    modport master (
        input  start, mode, din_valid, din_data, dout_ready,
               read_data, write_complete, read_complete,
        output busy, done, din_ready, dout_valid, dout_data,
               sdram_address, rd_en, wr_en, write_data_input
    );

    modport slave (
        output start, mode, din_valid, din_data, dout_ready,
               read_data, write_complete, read_complete,
        input  busy, done, din_ready, dout_valid, dout_data,
               sdram_address, rd_en, wr_en, write_data_input
    );
endinterface

// File: rtl/ddr3_frame_packer.sv
// Packs a frame of pixels into 128-bit SDRAM words (store) or unpacks them back
// into a pixel stream (fetch), one word transaction at a time.
module ddr3_frame_packer #(
    parameter int          BITS_PER_SYMBOL  = 8,
    parameter int          SYMBOLS_PER_BEAT = 3,
    parameter int          WIDTH            = 1280,
    parameter int          HEIGHT           = 720,
    parameter logic [31:0] BASE_ADDR        = 32'h0
) (
    input logic clk,
    input logic rst,
    ddr3_frame_packer_if.master bus
);
    localparam int PW     = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int PPW    = 128 / PW;
    localparam int TOTAL  = WIDTH * HEIGHT;
    localparam int NWORDS = (TOTAL + PPW - 1) / PPW;
    localparam int PC_W   = $clog2(TOTAL + 1);
    localparam int WI_W   = $clog2(NWORDS + 1);
    localparam int SL_W   = $clog2(PPW + 1);

    localparam logic [PC_W-1:0] LAST_PIX  = PC_W'(TOTAL - 1);
    localparam logic [WI_W-1:0] LAST_WORD = WI_W'(NWORDS - 1);
    localparam logic [SL_W-1:0] LAST_SLOT = SL_W'(PPW - 1);

    typedef enum logic [2:0] {IDLE, FILL, WRITE, READ, DRAIN} state_t;

    state_t          state_q;
    logic [PC_W-1:0] pix_cnt_q;
    logic [WI_W-1:0] word_idx_q;
    logic [SL_W-1:0] slot_q;
    logic [127:0]    fill_q;
    logic [127:0]    fill_d;
    logic [127:0]    wdata_q;
    logic [127:0]    sh_q;
    logic [PW-1:0]   dout_data_q;
    logic [31:0]     addr_q;
    logic            busy_q;
    logic            done_q;
    logic            din_ready_q;
    logic            dout_valid_q;
    logic            rd_en_q;
    logic            wr_en_q;

    function automatic logic [31:0] addr_of(input logic [WI_W-1:0] idx);
        return BASE_ADDR + (32'(idx) << 4);
    endfunction

    // The word buffer is cleared at every word boundary, so unused slots stay zero.
    assign fill_d = fill_q | (128'(bus.din_data) << (32'(slot_q) * PW));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            word_idx_q   <= '0;
            slot_q       <= '0;
            fill_q       <= '0;
            wdata_q      <= '0;
            sh_q         <= '0;
            dout_data_q  <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        pix_cnt_q  <= '0;
                        word_idx_q <= '0;
                        slot_q     <= '0;
                        fill_q     <= '0;
                        busy_q     <= 1'b1;
                        if (bus.mode) begin
                            state_q <= READ;
                            rd_en_q <= 1'b1;
                            addr_q  <= BASE_ADDR;
                        end else begin
                            state_q     <= FILL;
                            din_ready_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (bus.din_valid) begin
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                        if (slot_q == LAST_SLOT || pix_cnt_q == LAST_PIX) begin
                            state_q     <= WRITE;
                            din_ready_q <= 1'b0;
                            wr_en_q     <= 1'b1;
                            wdata_q     <= fill_d;
                            addr_q      <= addr_of(word_idx_q);
                            slot_q      <= '0;
                            fill_q      <= '0;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                            fill_q <= fill_d;
                        end
                    end
                end
                WRITE: begin
                    if (bus.write_complete) begin
                        wr_en_q    <= 1'b0;
                        word_idx_q <= word_idx_q + 1'b1;
                        if (word_idx_q == LAST_WORD) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= FILL;
                            din_ready_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // Slot 0 goes straight to the output; the rest waits in a shifter.
                    if (bus.read_complete) begin
                        state_q      <= DRAIN;
                        rd_en_q      <= 1'b0;
                        dout_valid_q <= 1'b1;
                        dout_data_q  <= bus.read_data[PW-1:0];
                        sh_q         <= bus.read_data >> PW;
                        slot_q       <= '0;
                    end
                end
                DRAIN: begin
                    if (bus.dout_ready) begin
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                        if (pix_cnt_q == LAST_PIX) begin
                            state_q      <= IDLE;
                            dout_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else if (slot_q == LAST_SLOT) begin
                            state_q      <= READ;
                            dout_valid_q <= 1'b0;
                            rd_en_q      <= 1'b1;
                            word_idx_q   <= word_idx_q + 1'b1;
                            addr_q       <= addr_of(word_idx_q + 1'b1);
                            slot_q       <= '0;
                        end else begin
                            slot_q      <= slot_q + 1'b1;
                            dout_data_q <= sh_q[PW-1:0];
                            sh_q        <= sh_q >> PW;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.din_ready        = din_ready_q;
    assign bus.dout_valid       = dout_valid_q;
    assign bus.dout_data        = dout_data_q;
    assign bus.sdram_address    = addr_q;
    assign bus.rd_en            = rd_en_q;
    assign bus.wr_en            = wr_en_q;
    assign bus.write_data_input = wdata_q;
endmodule

// File: tb/tb_ddr3_frame_packer.sv
// Directed bench: 4x2 frame with 24-bit pixels (5 per word) plus a 32-bit pixel variant.
module tb_ddr3_frame_packer;
    localparam logic [31:0] BASE0 = 32'h0000_1000;
    localparam logic [31:0] BASE1 = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr3_frame_packer_if #(.PW(24)) a ();
    ddr3_frame_packer_if #(.PW(32)) b ();

    ddr3_frame_packer #(
        .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .WIDTH(4), .HEIGHT(2), .BASE_ADDR(BASE0)
    ) u_dut24 (.clk(clk), .rst(rst), .bus(a));

    ddr3_frame_packer #(
        .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(4), .WIDTH(4), .HEIGHT(2), .BASE_ADDR(BASE1)
    ) u_dut32 (.clk(clk), .rst(rst), .bus(b));

    typedef struct {
        logic [191:0] pix;
        logic [127:0] w0;
        logic [127:0] w1;
        int           wc_delay;
    } vec_t;

    vec_t vecs [3];
    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic store(input int vi, input logic [191:0] pix, input logic [127:0] w0,
                         input logic [127:0] w1, input int wc_delay);
        logic [127:0] exp_w;
        int first;
        int cnt;
        int stable_bad;
        a.start = 1'b1;
        a.mode  = 1'b0;
        step();
        a.start = 1'b0;
        for (int w = 0; w < 2; w++) begin
            first = w * 5;
            cnt   = (w == 0) ? 5 : 3;
            exp_w = (w == 0) ? w0 : w1;
            chk("din_ready_fill", 128'(a.din_ready), 128'd1);
            for (int k = 0; k < cnt; k++) begin
                a.din_valid = 1'b1;
                a.din_data  = pix[(first + k) * 24 +: 24];
                step();
            end
            a.din_valid = 1'b0;
            chk("wr_en_asserted", 128'(a.wr_en), 128'd1);
            chk("wr_addr", 128'(a.sdram_address), 128'(BASE0 + 32'(w * 16)));
            chk("wr_data", a.write_data_input, exp_w);
            chk("rd_en_in_write", 128'(a.rd_en), 128'd0);
            stable_bad = 0;
            for (int d = 0; d < wc_delay; d++) begin
                step();
                if (a.wr_en !== 1'b1 || a.din_ready !== 1'b0 ||
                    a.sdram_address !== BASE0 + 32'(w * 16) || a.write_data_input !== exp_w)
                    stable_bad++;
            end
            if (wc_delay > 0) chk("write_hold_unstable_cycles", 128'(stable_bad), 128'd0);
            a.write_complete = 1'b1;
            step();
            a.write_complete = 1'b0;
            chk("wr_en_released", 128'(a.wr_en), 128'd0);
        end
        chk("store_done_pulse", 128'(a.done), 128'd1);
        chk("store_busy_idle", 128'(a.busy), 128'd0);
        step();
        chk("store_done_single", 128'(a.done), 128'd0);
        $display("store vec %0d: 2 words written, wc_delay %0d", vi, wc_delay);
    endtask

    task automatic fetch(input int vi, input logic [191:0] pix, input logic [127:0] w0,
                         input logic [127:0] w1);
        int got = 0;
        int rd_cnt = 0;
        int saw_done = 0;
        int held = 0;
        logic [23:0] held_data = '0;
        a.start = 1'b1;
        a.mode  = 1'b1;
        step();
        a.start = 1'b0;
        a.mode  = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (a.done) begin
                saw_done = 1;
                break;
            end
            a.start = (cyc == 3);
            chk("rd_wr_exclusive", 128'(a.rd_en & a.wr_en), 128'd0);
            if (held != 0 && a.dout_valid)
                chk("dout_hold", 128'(a.dout_data), 128'(held_data));
            if (a.rd_en) begin
                chk("rd_addr", 128'(a.sdram_address), 128'(BASE0 + 32'(rd_cnt * 16)));
                a.read_complete = 1'b1;
                a.read_data     = (rd_cnt == 0) ? w0 : w1;
                rd_cnt++;
            end else begin
                a.read_complete = 1'b0;
            end
            a.dout_ready = 1'($urandom_range(0, 1));
            held = 0;
            if (a.dout_valid && a.dout_ready) begin
                if (got < 8) chk("fetch_pixel", 128'(a.dout_data), 128'(pix[got * 24 +: 24]));
                got++;
            end else if (a.dout_valid) begin
                held = 1;
                held_data = a.dout_data;
            end
            step();
        end
        a.start = 1'b0;
        a.read_complete = 1'b0;
        a.dout_ready = 1'b0;
        chk("fetch_done_seen", 128'(saw_done), 128'd1);
        chk("fetch_pixel_count", 128'(got), 128'd8);
        chk("fetch_read_count", 128'(rd_cnt), 128'd2);
        step();
        chk("fetch_done_single", 128'(a.done), 128'd0);
        chk("fetch_busy_idle", 128'(a.busy), 128'd0);
        $display("fetch vec %0d: %0d pixels, %0d reads", vi, got, rd_cnt);
    endtask

    initial begin
        vecs[0].pix = {24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1};
        vecs[0].w0  = {8'h0, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1};
        vecs[0].w1  = {56'h0, 24'd8, 24'd7, 24'd6};
        vecs[0].wc_delay = 10;
        vecs[1].pix = {8{24'hFFFFFF}};
        vecs[1].w0  = {8'h0, {5{24'hFFFFFF}}};
        vecs[1].w1  = {56'h0, {3{24'hFFFFFF}}};
        vecs[1].wc_delay = 0;
        vecs[2].pix = {4{24'h5A5A5A, 24'hA5A5A5}};
        vecs[2].w0  = {8'h0, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5};
        vecs[2].w1  = {56'h0, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};
        vecs[2].wc_delay = 3;

        a.start = 0; a.mode = 0; a.din_valid = 0; a.din_data = '0; a.dout_ready = 0;
        a.read_data = '0; a.write_complete = 0; a.read_complete = 0;
        b.start = 0; b.mode = 0; b.din_valid = 0; b.din_data = '0; b.dout_ready = 0;
        b.read_data = '0; b.write_complete = 0; b.read_complete = 0;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_flags", 128'({a.busy, a.done, a.din_ready, a.dout_valid, a.rd_en, a.wr_en}), 128'd0);
        chk("reset_addr", 128'(a.sdram_address), 128'd0);
        chk("reset_wdata", a.write_data_input, 128'd0);
        chk("reset_dout", 128'(a.dout_data), 128'd0);
        $display("reset: outputs checked");

        for (int i = 0; i < 3; i++) begin
            store(i, vecs[i].pix, vecs[i].w0, vecs[i].w1, vecs[i].wc_delay);
            fetch(i, vecs[i].pix, vecs[i].w0, vecs[i].w1);
        end

        // Reset while a write is outstanding.
        a.start = 1'b1;
        a.mode  = 1'b0;
        step();
        a.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a.din_valid = 1'b1;
            a.din_data  = 24'h000100 + 24'(k);
            step();
        end
        a.din_valid = 1'b0;
        chk("pre_reset_wr_en", 128'(a.wr_en), 128'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_write_reset_wr_en", 128'(a.wr_en), 128'd0);
        chk("mid_write_reset_busy", 128'(a.busy), 128'd0);
        $display("reset during write: transaction abandoned");

        // Completion strobes in IDLE must not disturb anything.
        a.write_complete = 1'b1;
        a.read_complete  = 1'b1;
        step();
        a.write_complete = 1'b0;
        a.read_complete  = 1'b0;
        step();
        chk("idle_strobe_flags", 128'({a.busy, a.done, a.din_ready, a.dout_valid, a.rd_en, a.wr_en}), 128'd0);
        chk("idle_strobe_addr", 128'(a.sdram_address), 128'd0);
        $display("idle completion strobes ignored");

        store(3, vecs[0].pix, vecs[0].w0, vecs[0].w1, 0);
        fetch(3, vecs[0].pix, vecs[0].w0, vecs[0].w1);

        // 32-bit pixels: four per word, no padding.
        b.start = 1'b1;
        b.mode  = 1'b0;
        step();
        b.start = 1'b0;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) begin
                b.din_valid = 1'b1;
                b.din_data  = 32'hC0DE0001 + 32'(w * 4 + k);
                step();
            end
            b.din_valid = 1'b0;
            chk("pw32_wr_en", 128'(b.wr_en), 128'd1);
            chk("pw32_addr", 128'(b.sdram_address), 128'(BASE1 + 32'(w * 16)));
            if (w == 0)
                chk("pw32_word0", b.write_data_input,
                    {32'hC0DE0004, 32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001});
            else
                chk("pw32_word1", b.write_data_input,
                    {32'hC0DE0008, 32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005});
            b.write_complete = 1'b1;
            step();
            b.write_complete = 1'b0;
        end
        chk("pw32_done", 128'(b.done), 128'd1);
        chk("pw32_busy", 128'(b.busy), 128'd0);
        $display("store pw32: 2 words written");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
